// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: sigma constants, round defaults, FSM state type and
// small-sigma helpers evaluated on a 64-bit carrier for either word width.
package sha2_pkg;

  localparam int unsigned WINDOW_N   = 16;
  localparam int unsigned ROUNDS_256 = 64;
  localparam int unsigned ROUNDS_512 = 80;

  localparam int unsigned S0_R1_256 = 7;
  localparam int unsigned S0_R2_256 = 18;
  localparam int unsigned S0_SH_256 = 3;
  localparam int unsigned S1_R1_256 = 17;
  localparam int unsigned S1_R2_256 = 19;
  localparam int unsigned S1_SH_256 = 10;

  localparam int unsigned S0_R1_512 = 1;
  localparam int unsigned S0_R2_512 = 8;
  localparam int unsigned S0_SH_512 = 7;
  localparam int unsigned S1_R1_512 = 19;
  localparam int unsigned S1_R2_512 = 61;
  localparam int unsigned S1_SH_512 = 6;

  typedef enum logic {IDLE, RUN} state_t;

  // Rotate right within the low w bits; x must be zero above bit w-1.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n,
                                       input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((x >> n) | (x << (w - n))) & mask;
  endfunction

  function automatic logic [63:0] sigma0_small(input logic [63:0] x, input int unsigned w);
    if (w == 64)
      return rotr(x, S0_R1_512, 64) ^ rotr(x, S0_R2_512, 64) ^ (x >> S0_SH_512);
    return rotr(x, S0_R1_256, 32) ^ rotr(x, S0_R2_256, 32) ^ (x >> S0_SH_256);
  endfunction

  function automatic logic [63:0] sigma1_small(input logic [63:0] x, input int unsigned w);
    if (w == 64)
      return rotr(x, S1_R1_512, 64) ^ rotr(x, S1_R2_512, 64) ^ (x >> S1_SH_512);
    return rotr(x, S1_R1_256, 32) ^ rotr(x, S1_R2_256, 32) ^ (x >> S1_SH_256);
  endfunction

endpackage

// File: rtl/w_sched_sigma.sv
// Combinational small sigma of one schedule word; SEL_S1 picks s1 over s0.
module w_sched_sigma
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter bit          SEL_S1 = 1'b0
) (
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] sigma
);

  logic [63:0] wide;

  assign wide  = 64'(word);
  assign sigma = SEL_S1 ? WORD_W'(sigma1_small(wide, WORD_W))
                        : WORD_W'(sigma0_small(wide, WORD_W));

endmodule

// File: rtl/w_sched_stream.sv
// Streaming SHA-2 message schedule: one 16-word block in, W[0..ROUNDS-1] out
// over a valid/ready stream, generated from a 16-word sliding window.
module w_sched_stream
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = ROUNDS_256,
  parameter int unsigned IDX_W  = $clog2(ROUNDS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       block_valid,
  output logic                       block_ready,
  input  logic [WINDOW_N*WORD_W-1:0] message_block,
  input  logic                       flush,
  output logic                       w_valid,
  input  logic                       w_ready,
  output logic [WORD_W-1:0]          w_word,
  output logic [IDX_W-1:0]           w_index,
  output logic                       w_last,
  output logic                       busy
);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("w_sched_stream: WORD_W must be 32 or 64");
  end

  state_t            state, state_next;
  logic [WORD_W-1:0] window [WINDOW_N];
  logic [WORD_W-1:0] blk_word [WINDOW_N];
  logic [WORD_W-1:0] s0_w1, s1_w14, new_word;
  logic              last_c, load_c, adv_c;

  // Word 0 sits in the most significant slice of the block.
  for (genvar g = 0; g < WINDOW_N; g++) begin : g_unpack
    assign blk_word[g] = message_block[(WINDOW_N-1-g)*WORD_W +: WORD_W];
  end

  w_sched_sigma #(.WORD_W(WORD_W), .SEL_S1(1'b0)) u_s0 (.word(window[1]),  .sigma(s0_w1));
  w_sched_sigma #(.WORD_W(WORD_W), .SEL_S1(1'b1)) u_s1 (.word(window[14]), .sigma(s1_w14));

  assign new_word    = s1_w14 + window[9] + s0_w1 + window[0];
  assign last_c      = (w_index == IDX_W'(ROUNDS - 1));
  assign load_c      = (state == IDLE) && block_valid && !reset;
  assign adv_c       = (state == RUN) && w_ready && !flush;

  assign block_ready = (state == IDLE) && !reset;
  assign busy        = (state == RUN);
  assign w_valid     = (state == RUN);
  assign w_last      = (state == RUN) && last_c;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (block_valid) state_next = RUN;
      RUN: begin
        if (flush)                state_next = IDLE;
        else if (w_ready && last_c) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Presented word and round index; flush leaves the stale word but rewinds t.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_word  <= '0;
      w_index <= '0;
    end else if (load_c) begin
      w_word  <= blk_word[0];
      w_index <= '0;
    end else if (state == RUN && flush) begin
      w_index <= '0;
    end else if (adv_c) begin
      w_word  <= window[1];
      w_index <= last_c ? '0 : w_index + IDX_W'(1);
    end
  end

  // Window contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clock) begin
    if (load_c) begin
      for (int i = 0; i < WINDOW_N; i++) window[i] <= blk_word[i];
    end else if (adv_c) begin
      for (int i = 0; i < WINDOW_N-1; i++) window[i] <= window[i+1];
      window[WINDOW_N-1] <= new_word;
    end
  end

endmodule

// File: tb/tb_w_sched_stream.sv
// Bench for w_sched_stream: 32-bit and 64-bit instances against a direct
// recurrence model of the SHA-2 message schedule.
module tb_w_sched_stream;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         bv, br, flush, wv, wr, wl, busy;
  logic [511:0] mb;
  logic [31:0]  ww;
  logic [5:0]   wi;

  logic          bv64, br64, flush64, wv64, wr64, wl64, busy64;
  logic [1023:0] mb64;
  logic [63:0]   ww64;
  logic [6:0]    wi64;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp32 [64];
  logic [31:0] obs32 [64];
  logic [63:0] exp64 [80];

  w_sched_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clock(clock), .reset(reset), .block_valid(bv), .block_ready(br),
    .message_block(mb), .flush(flush), .w_valid(wv), .w_ready(wr),
    .w_word(ww), .w_index(wi), .w_last(wl), .busy(busy));

  w_sched_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clock(clock), .reset(reset), .block_valid(bv64), .block_ready(br64),
    .message_block(mb64), .flush(flush64), .w_valid(wv64), .w_ready(wr64),
    .w_word(ww64), .w_index(wi64), .w_last(wl64), .busy(busy64));

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic model32(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) exp32[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror32(exp32[t-15], 7) ^ ror32(exp32[t-15], 18) ^ (exp32[t-15] >> 3);
      s1 = ror32(exp32[t-2], 17) ^ ror32(exp32[t-2], 19) ^ (exp32[t-2] >> 10);
      exp32[t] = s1 + exp32[t-7] + s0 + exp32[t-16];
    end
  endtask

  task automatic model64(input logic [1023:0] blk);
    logic [63:0] s0, s1;
    for (int t = 0; t < 16; t++) exp64[t] = blk[1023 - 64*t -: 64];
    for (int t = 16; t < 80; t++) begin
      s0 = ror64(exp64[t-15], 1) ^ ror64(exp64[t-15], 8) ^ (exp64[t-15] >> 7);
      s1 = ror64(exp64[t-2], 19) ^ ror64(exp64[t-2], 61) ^ (exp64[t-2] >> 6);
      exp64[t] = s1 + exp64[t-7] + s0 + exp64[t-16];
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Present a block and return just after the accepting edge.
  task automatic offer32(input logic [511:0] blk);
    int n = 0;
    mb = blk;
    bv = 1'b1;
    while (br !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (br !== 1'b1) begin
      errors++;
      $display("FAIL accept32: block_ready=%b after %0d cycles, want 1", br, n);
    end
    tick();
    bv = 1'b0;
  endtask

  // Consume all 64 words (optionally with random stalls), then check the idle bubble.
  task automatic drain32(input bit stall);
    int cnt = 0, cyc = 0;
    bit held = 1'b0, hs;
    logic [31:0] pw;
    logic [5:0]  pi;
    logic        pl;
    while (cnt < 64 && cyc < 2000) begin
      wr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      checks++;
      if (wv !== 1'b1 || wi !== 6'(cnt) || ww !== exp32[cnt] || wl !== (cnt == 63) || br !== 1'b0) begin
        errors++;
        $display("FAIL word32 t=%0d: got v=%b i=%0d w=%h l=%b rdy=%b, want v=1 i=%0d w=%h l=%b rdy=0",
                 cnt, wv, wi, ww, wl, br, cnt, exp32[cnt], (cnt == 63));
      end
      if (held) begin
        checks++;
        if ({ww, wi, wl} !== {pw, pi, pl}) begin
          errors++;
          $display("FAIL stall_hold32: got w=%h i=%0d l=%b, want w=%h i=%0d l=%b", ww, wi, wl, pw, pi, pl);
        end
      end
      obs32[cnt] = ww;
      pw = ww; pi = wi; pl = wl;
      hs = wr;
      held = !wr;
      tick();
      cyc++;
      if (hs) cnt++;
    end
    wr = 1'b0;
    checks++;
    if (cnt != 64 || wv !== 1'b0 || busy !== 1'b0 || br !== 1'b1) begin
      errors++;
      $display("FAIL end32: got words=%0d v=%b busy=%b rdy=%b, want words=64 v=0 busy=0 rdy=1",
               cnt, wv, busy, br);
    end
  endtask

  // Advance a running block with w_ready=1 until W[stop] is presented.
  task automatic run_to32(input int stop);
    wr = 1'b1;
    for (int k = 0; k < stop; k++) begin
      checks++;
      if (wv !== 1'b1 || ww !== exp32[k] || wi !== 6'(k)) begin
        errors++;
        $display("FAIL run32 t=%0d: got v=%b i=%0d w=%h, want v=1 i=%0d w=%h", k, wv, wi, ww, k, exp32[k]);
      end
      tick();
    end
    wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({br, wv, ww, wi, wl, busy} !== '0) begin
      errors++;
      $display("FAIL reset32: got rdy=%b v=%b w=%h i=%0d l=%b busy=%b, want all 0", br, wv, ww, wi, wl, busy);
    end
    checks++;
    if ({br64, wv64, ww64, wi64, wl64, busy64} !== '0) begin
      errors++;
      $display("FAIL reset64: got rdy=%b v=%b w=%h i=%0d l=%b busy=%b, want all 0",
               br64, wv64, ww64, wi64, wl64, busy64);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (br !== 1'b1 || br64 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b/%b, want 1/1", br, br64);
    end
  endtask

  task automatic test_abc32();
    logic [511:0] blk = '0;
    blk[511 -: 32] = 32'h6162_6380;
    blk[31:0]      = 32'h0000_0018;
    model32(blk);
    offer32(blk);
    drain32(1'b0);
    checks++;
    if (obs32[16] !== 32'h6162_6380 || obs32[17] !== 32'h000F_0000) begin
      errors++;
      $display("FAIL abc32_w16_w17: got %h %h, want 61626380 000f0000", obs32[16], obs32[17]);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] blk;
    for (int r = 0; r < 3; r++) begin
      blk = rand_blk();
      model32(blk);
      offer32(blk);
      drain32(1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] a = rand_blk();
    logic [511:0] b = rand_blk();
    model32(a);
    offer32(a);
    mb = b;
    bv = 1'b1;
    drain32(1'b0);
    model32(b);
    tick();
    bv = 1'b0;
    drain32(1'b0);
  endtask

  task automatic test_flush();
    logic [511:0] a = rand_blk();
    logic [511:0] b = rand_blk();
    model32(a);
    offer32(a);
    run_to32(20);
    checks++;
    if (wi !== 6'd20 || ww !== exp32[20]) begin
      errors++;
      $display("FAIL flush_pre: got i=%0d w=%h, want i=20 w=%h", wi, ww, exp32[20]);
    end
    flush = 1'b1;
    wr = 1'b1;
    tick();
    flush = 1'b0;
    wr = 1'b0;
    checks++;
    if (wv !== 1'b0 || busy !== 1'b0 || wi !== 6'd0 || br !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: got v=%b busy=%b i=%0d rdy=%b, want v=0 busy=0 i=0 rdy=1", wv, busy, wi, br);
    end
    // flush held in IDLE must not prevent acceptance
    model32(b);
    mb = b;
    bv = 1'b1;
    flush = 1'b1;
    tick();
    bv = 1'b0;
    flush = 1'b0;
    drain32(1'b0);
  endtask

  task automatic test_reset_mid_run();
    logic [511:0] a = rand_blk();
    model32(a);
    offer32(a);
    run_to32(40);
    reset = 1'b1;
    tick();
    checks++;
    if ({br, wv, ww, wi, wl, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b v=%b w=%h i=%0d l=%b busy=%b, want all 0", br, wv, ww, wi, wl, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (br !== 1'b1 || wv !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", br, wv);
    end
    a = rand_blk();
    model32(a);
    offer32(a);
    drain32(1'b0);
  endtask

  task automatic test_abc64();
    logic [1023:0] blk = '0;
    int cnt = 0, n = 0;
    blk[1023 -: 64] = 64'h6162_6380_0000_0000;
    blk[63:0]       = 64'h0000_0000_0000_0018;
    model64(blk);
    mb64 = blk;
    bv64 = 1'b1;
    while (br64 !== 1'b1 && n < 200) begin tick(); n++; end
    tick();
    bv64 = 1'b0;
    wr64 = 1'b1;
    while (cnt < 80 && n < 1000) begin
      checks++;
      if (wv64 !== 1'b1 || wi64 !== 7'(cnt) || ww64 !== exp64[cnt] || wl64 !== (cnt == 79)) begin
        errors++;
        $display("FAIL word64 t=%0d: got v=%b i=%0d w=%h l=%b, want v=1 i=%0d w=%h l=%b",
                 cnt, wv64, wi64, ww64, wl64, cnt, exp64[cnt], (cnt == 79));
      end
      tick();
      cnt++;
      n++;
    end
    wr64 = 1'b0;
    checks++;
    if (wv64 !== 1'b0 || br64 !== 1'b1) begin
      errors++;
      $display("FAIL end64: got v=%b rdy=%b, want v=0 rdy=1", wv64, br64);
    end
  endtask

  initial begin
    reset = 1'b1;
    bv = 1'b0; flush = 1'b0; wr = 1'b0; mb = '0;
    bv64 = 1'b0; flush64 = 1'b0; wr64 = 1'b0; mb64 = '0;
    test_reset();
    test_abc32();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    test_abc64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
